// File: rtl/mm_operand_feeder_pkg.sv
// Shared parameters and state encoding for the matrix-multiply operand path.
package mm_operand_feeder_pkg;

   localparam int DEFAULT_DATA_WIDTH = 8;
   localparam int DEFAULT_N          = 4;

   typedef enum logic [2:0] {
      LOAD,
      FEED,
      WAIT,
      HOLD,
      CLEAR
   } feeder_state_e;

   // A systolic array of dimension n needs the skewed stream to run for 3n-2 beats.
   function automatic int feed_beats(input int n);
      return 3 * n - 2;
   endfunction

endpackage

// File: rtl/mm_operand_feeder_buffer.sv
// N-entry operand register file: one A column and one B row per entry.
module mm_operand_buffer
   import mm_operand_feeder_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int N          = DEFAULT_N,
   localparam int IW        = $clog2(N)
) (
   input  logic                             clk_i,
   input  logic                             wr_en,
   input  logic [IW-1:0]                    wr_idx,
   input  logic [N-1:0][DATA_WIDTH-1:0]     wr_a,
   input  logic [N-1:0][DATA_WIDTH-1:0]     wr_b,
   input  logic [IW-1:0]                    rd_idx,
   output logic [N-1:0][DATA_WIDTH-1:0]     rd_a,
   output logic [N-1:0][DATA_WIDTH-1:0]     rd_b
);

   logic [N-1:0][DATA_WIDTH-1:0] mem_a [N];
   logic [N-1:0][DATA_WIDTH-1:0] mem_b [N];

   // Contents are never read before being written, so no reset is needed.
   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         mem_a[wr_idx] <= wr_a;
         mem_b[wr_idx] <= wr_b;
      end
   end

   assign rd_a = mem_a[rd_idx];
   assign rd_b = mem_b[rd_idx];

endmodule

// File: rtl/mm_operand_feeder.sv
// Collects N operand beats, streams them (plus zero flush) into the array,
// then holds until the consumer acknowledges the results and clears the array.
module mm_operand_feeder
   import mm_operand_feeder_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int N          = DEFAULT_N
) (
   input  logic                             clk_i,
   input  logic                             reset_i,
   input  logic                             in_valid_i,
   output logic                             in_ready_o,
   input  logic [N-1:0][DATA_WIDTH-1:0]     in_a_i,
   input  logic [N-1:0][DATA_WIDTH-1:0]     in_b_i,
   output logic                             mm_valid_o,
   output logic [N-1:0][DATA_WIDTH-1:0]     mm_a_o,
   output logic [N-1:0][DATA_WIDTH-1:0]     mm_b_o,
   input  logic                             mm_valid_i,
   output logic                             mm_reset_o,
   output logic                             done_o,
   input  logic                             result_ack_i
);

   localparam int CW        = $clog2(3 * N - 1);
   localparam int IW        = $clog2(N);
   localparam int LAST_FEED = feed_beats(N) - 1;

   feeder_state_e                state;
   logic [CW-1:0]                load_cnt;
   logic [CW-1:0]                feed_cnt;
   logic [CW-1:0]                next_feed;
   logic                         next_is_data;
   logic [IW-1:0]                rd_idx;
   logic                         wr_en;
   logic [N-1:0][DATA_WIDTH-1:0] rd_a;
   logic [N-1:0][DATA_WIDTH-1:0] rd_b;

   assign wr_en = in_valid_i && in_ready_o;

   // Outputs are registered, so the buffer is read one beat ahead of what is presented.
   always_comb begin
      next_feed    = feed_cnt + CW'(1);
      next_is_data = 1'b0;
      rd_idx       = '0;
      if (state == FEED && next_feed < CW'(N)) begin
         next_is_data = 1'b1;
         rd_idx       = next_feed[IW-1:0];
      end
   end

   mm_operand_buffer #(
      .DATA_WIDTH (DATA_WIDTH),
      .N          (N)
   ) u_buffer (
      .clk_i  (clk_i),
      .wr_en  (wr_en),
      .wr_idx (load_cnt[IW-1:0]),
      .wr_a   (in_a_i),
      .wr_b   (in_b_i),
      .rd_idx (rd_idx),
      .rd_a   (rd_a),
      .rd_b   (rd_b)
   );

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state      <= LOAD;
         load_cnt   <= '0;
         feed_cnt   <= '0;
         in_ready_o <= 1'b1;
         mm_valid_o <= 1'b0;
         mm_a_o     <= '0;
         mm_b_o     <= '0;
         done_o     <= 1'b0;
      end else begin
         case (state)
            LOAD: begin
               if (wr_en) begin
                  load_cnt <= load_cnt + CW'(1);
                  if (load_cnt == CW'(N - 1)) begin
                     state      <= FEED;
                     in_ready_o <= 1'b0;
                     feed_cnt   <= '0;
                     mm_valid_o <= 1'b1;
                     mm_a_o     <= rd_a;
                     mm_b_o     <= rd_b;
                  end
               end
            end
            FEED: begin
               if (feed_cnt == CW'(LAST_FEED)) begin
                  state      <= WAIT;
                  feed_cnt   <= '0;
                  mm_valid_o <= 1'b0;
                  mm_a_o     <= '0;
                  mm_b_o     <= '0;
               end else begin
                  feed_cnt   <= next_feed;
                  mm_valid_o <= 1'b1;
                  mm_a_o     <= next_is_data ? rd_a : '0;
                  mm_b_o     <= next_is_data ? rd_b : '0;
               end
            end
            WAIT: begin
               if (mm_valid_i) begin
                  state  <= HOLD;
                  done_o <= 1'b1;
               end
            end
            HOLD: begin
               if (result_ack_i) begin
                  state  <= CLEAR;
                  done_o <= 1'b0;
               end
            end
            CLEAR: begin
               state      <= LOAD;
               load_cnt   <= '0;
               in_ready_o <= 1'b1;
            end
            default: begin
               state <= LOAD;
            end
         endcase
      end
   end

   // The array must also be reset whenever the feeder itself is reset.
   assign mm_reset_o = reset_i || (state == CLEAR);

endmodule

// File: tb/tb_mm_operand_feeder.sv
// Self-checking bench: randomized operand loads checked against a transaction-level model.
module tb_mm_operand_feeder;

   localparam int DW    = 8;
   localparam int N     = 4;
   localparam int BEATS = 3 * N - 2;

   typedef logic [N-1:0][DW-1:0] vec_t;

   logic clk_i;
   logic reset_i;
   logic in_valid_i;
   logic in_ready_o;
   vec_t in_a_i;
   vec_t in_b_i;
   logic mm_valid_o;
   vec_t mm_a_o;
   vec_t mm_b_o;
   logic mm_valid_i;
   logic mm_reset_o;
   logic done_o;
   logic result_ack_i;

   int compared   = 0;
   int mismatched = 0;

   vec_t col_a [N];
   vec_t row_b [N];
   int   c_exp [N][N];
   int   c_obs [N][N];

   mm_operand_feeder #(
      .DATA_WIDTH (DW),
      .N          (N)
   ) dut (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .in_valid_i   (in_valid_i),
      .in_ready_o   (in_ready_o),
      .in_a_i       (in_a_i),
      .in_b_i       (in_b_i),
      .mm_valid_o   (mm_valid_o),
      .mm_a_o       (mm_a_o),
      .mm_b_o       (mm_b_o),
      .mm_valid_i   (mm_valid_i),
      .mm_reset_o   (mm_reset_o),
      .done_o       (done_o),
      .result_ack_i (result_ack_i)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Watchdog so the run always ends even if the sequencing goes astray.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // mode 0: random, 1: identity A with B rows 1..16, 2: all twos.
   task automatic buildOperands(input int mode);
      for (int k = 0; k < N; k++) begin
         for (int i = 0; i < N; i++) begin
            case (mode)
               1: begin
                  col_a[k][i] = (i == k) ? 8'd1 : 8'd0;
                  row_b[k][i] = DW'(4 * k + i + 1);
               end
               2: begin
                  col_a[k][i] = 8'd2;
                  row_b[k][i] = 8'd2;
               end
               default: begin
                  col_a[k][i] = DW'($urandom_range(0, 255));
                  row_b[k][i] = DW'($urandom_range(0, 255));
               end
            endcase
         end
      end
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            c_exp[i][j] = 0;
            c_obs[i][j] = 0;
            for (int k = 0; k < N; k++) begin
               c_exp[i][j] += int'(col_a[k][i]) * int'(row_b[k][j]);
            end
         end
      end
   endtask

   // One complete operation; abort_at >= 0 asserts reset on that feed beat and returns.
   task automatic applyStimulus(input int mode, input bit ack_noise, input bit early_mm_valid,
                                input int abort_at);
      vec_t exp_a;
      vec_t exp_b;
      int   gap;
      int   hold_cycles;
      buildOperands(mode);
      result_ack_i = ack_noise;
      mm_valid_i   = 1'b0;

      for (int k = 0; k < N; k++) begin
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) begin
            in_valid_i = 1'b0;
            in_a_i     = vec_t'($urandom);
            in_b_i     = vec_t'($urandom);
            checkOutput("ready_in_load_gap", in_ready_o, 1'b1);
            tick();
         end
         in_valid_i = 1'b1;
         in_a_i     = col_a[k];
         in_b_i     = row_b[k];
         checkOutput("ready_in_load", in_ready_o, 1'b1);
         checkOutput("valid_low_in_load", mm_valid_o, 1'b0);
         tick();
      end
      in_valid_i = 1'b0;
      in_a_i     = vec_t'($urandom);
      in_b_i     = vec_t'($urandom);
      checkOutput("ready_low_after_load", in_ready_o, 1'b0);

      for (int t = 0; t < BEATS; t++) begin
         exp_a = (t < N) ? col_a[t] : '0;
         exp_b = (t < N) ? row_b[t] : '0;
         checkOutput($sformatf("feed_valid_%0d", t), mm_valid_o, 1'b1);
         checkOutput($sformatf("feed_a_%0d", t), mm_a_o, exp_a);
         checkOutput($sformatf("feed_b_%0d", t), mm_b_o, exp_b);
         if (t == abort_at) begin
            reset_i = 1'b1;
            #1;
            checkOutput("mm_reset_during_reset", mm_reset_o, 1'b1);
            tick();
            checkOutput("abort_valid_low", mm_valid_o, 1'b0);
            checkOutput("abort_a_zero", mm_a_o, '0);
            checkOutput("abort_ready_high", in_ready_o, 1'b1);
            checkOutput("abort_done_low", done_o, 1'b0);
            reset_i = 1'b0;
            result_ack_i = 1'b0;
            #1;
            checkOutput("mm_reset_released", mm_reset_o, 1'b0);
            return;
         end
         for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
               c_obs[i][j] += int'(mm_a_o[i]) * int'(mm_b_o[j]);
            end
         end
         mm_valid_i = early_mm_valid;
         tick();
      end

      checkOutput("wait_valid_low", mm_valid_o, 1'b0);
      checkOutput("wait_a_zero", mm_a_o, '0);
      checkOutput("wait_b_zero", mm_b_o, '0);
      checkOutput("wait_done_low", done_o, 1'b0);
      checkOutput("wait_ready_low", in_ready_o, 1'b0);
      if (!early_mm_valid) begin
         gap = $urandom_range(0, 4);
         for (int g = 0; g < gap; g++) begin
            tick();
            checkOutput("wait_done_still_low", done_o, 1'b0);
         end
         mm_valid_i = 1'b1;
      end
      tick();
      mm_valid_i = 1'b0;
      checkOutput("hold_done_high", done_o, 1'b1);
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            checkOutput($sformatf("c_%0d_%0d", i, j), c_obs[i][j], c_exp[i][j]);
         end
      end

      hold_cycles = ack_noise ? 0 : $urandom_range(0, 3);
      if (!ack_noise) begin
         result_ack_i = 1'b0;
         for (int h = 0; h < hold_cycles; h++) begin
            tick();
            checkOutput("hold_done_kept", done_o, 1'b1);
         end
      end
      result_ack_i = 1'b1;
      tick();
      result_ack_i = 1'b0;
      checkOutput("clear_done_low", done_o, 1'b0);
      checkOutput("clear_mm_reset", mm_reset_o, 1'b1);
      checkOutput("clear_ready_low", in_ready_o, 1'b0);
      tick();
      checkOutput("after_clear_mm_reset_low", mm_reset_o, 1'b0);
      checkOutput("after_clear_ready_high", in_ready_o, 1'b1);
   endtask

   initial begin
      reset_i      = 1'b1;
      in_valid_i   = 1'b0;
      in_a_i       = '0;
      in_b_i       = '0;
      mm_valid_i   = 1'b0;
      result_ack_i = 1'b0;
      #1;
      checkOutput("mm_reset_follows_reset", mm_reset_o, 1'b1);
      tick();
      tick();
      checkOutput("reset_ready", in_ready_o, 1'b1);
      checkOutput("reset_valid", mm_valid_o, 1'b0);
      checkOutput("reset_a", mm_a_o, '0);
      checkOutput("reset_b", mm_b_o, '0);
      checkOutput("reset_done", done_o, 1'b0);
      reset_i = 1'b0;
      #1;
      checkOutput("mm_reset_low_after_reset", mm_reset_o, 1'b0);

      applyStimulus(1, 1'b0, 1'b0, -1);
      applyStimulus(2, 1'b0, 1'b0, -1);
      applyStimulus(2, 1'b1, 1'b1, -1);
      applyStimulus(0, 1'b0, 1'b1, 5);
      applyStimulus(0, 1'b0, 1'b0, -1);
      for (int r = 0; r < 6; r++) begin
         applyStimulus(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/mm_operand_feeder.md
MM_OPERAND_FEEDER -- requirements
Module: mm_operand_feeder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, operand element width in bits.
REQ-002 SHALL have parameter N, default 4, matrix dimension (N>=2).
REQ-003 SHALL have port clk_i  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_i  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid_i  input  1  operand beat k offered.
REQ-006 SHALL have port in_ready_o  output  1  feeder accepts a beat.
REQ-007 SHALL have port in_a_i  input  N x DATA_WIDTH  column k of A (element i = A[i][k]).
REQ-008 SHALL have port in_b_i  input  N x DATA_WIDTH  row k of B (element j = B[k][j]).
REQ-009 SHALL have port mm_valid_o  output  1  drives the multiplier array valid input.
REQ-010 SHALL have port mm_a_o, mm_b_o  output  N x DATA_WIDTH each  drive the array a/b inputs.
REQ-011 SHALL have port mm_valid_i  input  1  array result-valid.
REQ-012 SHALL have port mm_reset_o  output  1  reset to the array.
REQ-013 SHALL have port done_o  output  1  array results valid and held.
REQ-014 SHALL have port result_ack_i  input  1  consumer has read the array results.

Function
REQ-015 SHALL implement states LOAD, FEED, WAIT, HOLD, CLEAR.
REQ-016 LOAD: in_ready_o=1; beat accepted when in_valid_i&&in_ready_o, stored at buffer index load_cnt, load_cnt increments.
REQ-017 LOAD->FEED the cycle after the N-th beat is accepted; in_ready_o=0 in all other states.
REQ-018 FEED: mm_valid_o=1 for exactly 3N-2 consecutive cycles, feed_cnt 0..3N-3.
REQ-019 FEED beats 0..N-1 SHALL present buffer[feed_cnt] on mm_a_o/mm_b_o; beats N..3N-3 SHALL present all zeros.
REQ-020 FEED->WAIT after beat 3N-3; mm_valid_o=0 and mm_a_o/mm_b_o=0 outside FEED.
REQ-021 WAIT->HOLD when mm_valid_i=1; if mm_valid_i already 1 during FEED, transition still occurs only after FEED completes.
REQ-022 HOLD: done_o=1; stay until result_ack_i=1, then ->CLEAR.
REQ-023 CLEAR: mm_reset_o=1 for exactly one cycle, load_cnt cleared, then ->LOAD.
REQ-024 result_ack_i SHALL be ignored in every state except HOLD.
REQ-025 Counters SHALL be sized $clog2(3N-1) bits; no wrap-around permitted within a state.
REQ-026 mm_reset_o SHALL equal reset_i OR (state==CLEAR), so the array is reset whenever the feeder is.

Reset
REQ-027 On reset_i: state=LOAD, load_cnt=0, feed_cnt=0, in_ready_o=1 next cycle, mm_valid_o=0, mm_a_o/mm_b_o=0, done_o=0.
REQ-028 Buffer contents need not be reset; never presented before being written.
REQ-029 Reset mid-LOAD/FEED/WAIT/HOLD SHALL abandon the operation; partially loaded beats discarded.

Structure
REQ-030 DATA_WIDTH, N defaults and state enum SHALL live in the shared common parameters package used by the array.
REQ-031 Operand buffer SHALL be a sub-module mm_operand_buffer (N-entry, write-indexed, read-indexed register file).
REQ-032 Output registers SHALL be flopped; mm_reset_o alone may be combinational per REQ-026.

Verification (N=4, DATA_WIDTH=8)
REQ-033 Load A=identity, B=rows {1,2,3,4},{5,6,7,8},... back-to-back -> in_ready_o low after 4th beat; mm_valid_o high exactly 10 cycles; beats 4..9 zero.
REQ-034 Feeder driving real array with A=B=all-2 -> done_o asserts, array c_o all 16; ack -> mm_reset_o one-cycle pulse, in_ready_o=1 next cycle.
REQ-035 in_valid_i toggling 1/0 during LOAD -> exactly 4 beats stored in order; FEED order matches acceptance order.
REQ-036 result_ack_i held high throughout LOAD/FEED/WAIT -> no effect; HOLD exits on first cycle with ack.
REQ-037 reset_i asserted on FEED beat 5 -> mm_valid_o=0 next cycle, mm_reset_o=1 during reset, state LOAD, load_cnt=0.
REQ-038 Two consecutive full operations -> second result independent of first (array cleared between).
